// File: rtl/hilo_retire_stage_if.sv
// hilo_retire_stage_if: ALU-side push bus and write-back-side pop bus of the retire stage.
interface hilo_retire_stage_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_result_i;
    logic        in_zero_i;
    logic [2:0]  in_op_i;
    logic [4:0]  in_rd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [4:0]  out_rd_o;
    logic        out_zero_o;
    logic        out_wb_en_o;

    modport master (
        output in_valid_i, in_result_i, in_zero_i, in_op_i, in_rd_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_rd_o, out_zero_o, out_wb_en_o
    );
    modport slave (
        input  in_valid_i, in_result_i, in_zero_i, in_op_i, in_rd_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_rd_o, out_zero_o, out_wb_en_o
    );
endinterface

// File: rtl/hilo_retire_stage.sv
// hilo_retire_stage: in-order result FIFO that commits HI/LO on retirement and forms the write-back value.
// Define HILO_PERF_CNT_EN to add the perf_retired_o retired-entry counter.
module hilo_retire_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    hilo_retire_stage_if.slave      bus,
    input  logic                    flush_i,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o
`ifdef HILO_PERF_CNT_EN
    ,
    output logic [31:0]             perf_retired_o
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] OP_WRHL = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic [2:0]  op;
        logic [4:0]  rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            push, pop;

    assign head            = mem_q[rd_ptr_q];
    assign bus.in_ready_o  = count_q < CNT_W'(DEPTH);
    assign bus.out_valid_o = count_q != '0;
    assign push            = bus.in_valid_i & bus.in_ready_o & !flush_i;
    assign pop             = bus.out_valid_o & bus.out_ready_i & !flush_i;

    // Write-back view depends only on the head entry and committed HI/LO.
    assign bus.out_data_o  = head.op == OP_MFHI ? hi_q :
                             head.op == OP_MFLO ? lo_q : head.result[31:0];
    assign bus.out_rd_o    = head.rd;
    assign bus.out_zero_o  = head.zero;
    assign bus.out_wb_en_o = (head.op == 3'd0 || head.op >= OP_MFHI) && head.rd != 5'd0;
    assign hi_o            = hi_q;
    assign lo_o            = lo_q;

    always_comb begin
        count_d  = flush_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop);
        hi_d     = pop && head.op == OP_WRHL ? head.result[63:32] :
                   pop && head.op == OP_MTHI ? head.result[31:0] : hi_q;
        lo_d     = pop && (head.op == OP_WRHL || head.op == OP_MTLO) ? head.result[31:0] : lo_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= '{bus.in_result_i, bus.in_zero_i, bus.in_op_i, bus.in_rd_i};
    end

`ifdef HILO_PERF_CNT_EN
    logic [31:0] perf_q;
    assign perf_retired_o = perf_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            perf_q <= '0;
        else if (pop)
            perf_q <= perf_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hilo_retire_stage.sv
// tb_hilo_retire_stage: directed checks of push/pop, HI/LO commit, stall, flush and reset.
module tb_hilo_retire_stage;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] hi_o, lo_o;
    int          checks = 0;
    int          errors = 0;
`ifdef HILO_PERF_CNT_EN
    logic [31:0] perf_retired_o;
`endif

    hilo_retire_stage_if bif ();

    hilo_retire_stage dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .bus            (bif),
        .flush_i        (flush_i),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
`ifdef HILO_PERF_CNT_EN
        ,
        .perf_retired_o (perf_retired_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] res, input logic [4:0] rd);
        bif.in_valid_i  = v;
        bif.in_op_i     = op;
        bif.in_result_i = res;
        bif.in_rd_i     = rd;
        bif.in_zero_i   = (res[31:0] == 32'd0);
    endtask

    initial begin
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        bif.out_ready_i = 1'b0;
        repeat (2) tick();
        rst_n_i = 1'b1;
        chk("rst_ready", bif.in_ready_o, 1);
        chk("rst_valid", bif.out_valid_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);

        // WRHL then MFHI with consumer always ready
        bif.out_ready_i = 1'b1;
        drive(1'b1, 3'd1, 64'h00000003_00000005, 5'd0);
        tick();
        chk("wrhl_valid", bif.out_valid_o, 1);
        chk("wrhl_data", bif.out_data_o, 5);
        chk("wrhl_wb", bif.out_wb_en_o, 0);
        drive(1'b1, 3'd4, 64'd0, 5'd4);
        tick();
        chk("mfhi_data", bif.out_data_o, 3);
        chk("mfhi_rd", bif.out_rd_o, 4);
        chk("mfhi_wb", bif.out_wb_en_o, 1);
        chk("wrhl_hi", hi_o, 3);
        chk("wrhl_lo", lo_o, 5);
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();
        chk("drain1_valid", bif.out_valid_o, 0);

        // Fill to DEPTH with consumer stalled; third entry must wait
        bif.out_ready_i = 1'b0;
        drive(1'b1, 3'd0, 64'h11, 5'd1);
        tick();
        drive(1'b1, 3'd0, 64'h22, 5'd2);
        tick();
        chk("full_ready", bif.in_ready_o, 0);
        drive(1'b1, 3'd0, 64'h33, 5'd3);
        tick();
        chk("stall_head", bif.out_data_o, 32'h11);
        chk("stall_ready", bif.in_ready_o, 0);
        bif.out_ready_i = 1'b1;
        tick();
        chk("order_2", bif.out_data_o, 32'h22);
        chk("order_2_ready", bif.in_ready_o, 1);
        tick();
        chk("order_3", bif.out_data_o, 32'h33);
        chk("order_3_rd", bif.out_rd_o, 3);
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();
        chk("drain2_valid", bif.out_valid_o, 0);

        // Flush an unretired MTLO; push/pop in the flush cycle are ignored
        bif.out_ready_i = 1'b0;
        drive(1'b1, 3'd3, 64'h00000000_DEADBEEF, 5'd0);
        tick();
        chk("mtlo_queued", bif.out_valid_o, 1);
        drive(1'b1, 3'd0, 64'h99, 5'd5);
        bif.out_ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        chk("flush_valid", bif.out_valid_o, 0);
        chk("flush_lo", lo_o, 5);
        chk("flush_ready", bif.in_ready_o, 1);

        // wb_en for rd=0 and for op 6 behaving as ALU
        bif.out_ready_i = 1'b0;
        drive(1'b1, 3'd0, 64'h7, 5'd0);
        tick();
        chk("rd0_wb", bif.out_wb_en_o, 0);
        chk("rd0_data", bif.out_data_o, 7);
        chk("zero_flag", bif.out_zero_o, 0);
        bif.out_ready_i = 1'b1;
        drive(1'b1, 3'd6, 64'hFFFF0000_00000000, 5'd2);
        tick();
        chk("op6_wb", bif.out_wb_en_o, 1);
        chk("op6_data", bif.out_data_o, 0);
        chk("op6_zero", bif.out_zero_o, 1);
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();

        // MTHI retires before the MFHI behind it reads HI
        drive(1'b1, 3'd2, 64'hFFFFFFFF_AAAA5555, 5'd0);
        tick();
        drive(1'b1, 3'd4, 64'd0, 5'd7);
        tick();
        chk("mthi_hi", hi_o, 32'hAAAA5555);
        chk("mthi_lo", lo_o, 5);
        chk("mfhi2_data", bif.out_data_o, 32'hAAAA5555);
        drive(1'b1, 3'd3, 64'hFFFFFFFF_12345678, 5'd0);
        tick();
        drive(1'b1, 3'd5, 64'd0, 5'd9);
        tick();
        chk("mtlo_lo", lo_o, 32'h12345678);
        chk("mtlo_hi", hi_o, 32'hAAAA5555);
        chk("mflo_data", bif.out_data_o, 32'h12345678);
        chk("mflo_wb", bif.out_wb_en_o, 1);
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();
        chk("drain3_valid", bif.out_valid_o, 0);
`ifdef HILO_PERF_CNT_EN
        chk("perf_11", perf_retired_o, 11);
`endif

        // Retire 2, flush 1, retire 3
        drive(1'b1, 3'd0, 64'hA1, 5'd1);
        tick();
        drive(1'b1, 3'd0, 64'hA2, 5'd1);
        tick();
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();
        bif.out_ready_i = 1'b0;
        drive(1'b1, 3'd0, 64'hC0, 5'd1);
        tick();
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bif.out_ready_i = 1'b1;
        drive(1'b1, 3'd0, 64'hD1, 5'd1);
        tick();
        chk("post_flush_head", bif.out_data_o, 32'hD1);
        drive(1'b1, 3'd0, 64'hD2, 5'd1);
        tick();
        drive(1'b1, 3'd0, 64'hD3, 5'd1);
        tick();
        chk("post_flush_d3", bif.out_data_o, 32'hD3);
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        tick();
        chk("drain4_valid", bif.out_valid_o, 0);
`ifdef HILO_PERF_CNT_EN
        chk("perf_16", perf_retired_o, 16);
`endif

        // Asynchronous reset with two entries queued
        bif.out_ready_i = 1'b0;
        drive(1'b1, 3'd1, 64'h00000009_00000008, 5'd1);
        tick();
        drive(1'b1, 3'd0, 64'h44, 5'd1);
        tick();
        drive(1'b0, 3'd0, 64'd0, 5'd0);
        chk("pre_rst_full", bif.in_ready_o, 0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_valid", bif.out_valid_o, 0);
        chk("arst_hi", hi_o, 0);
        chk("arst_lo", lo_o, 0);
`ifdef HILO_PERF_CNT_EN
        chk("arst_perf", perf_retired_o, 0);
`endif
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("post_rst_ready", bif.in_ready_o, 1);
        chk("post_rst_valid", bif.out_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
